varint_decode_push: RTL

- Writer side of the varint output FIFO. Consumes a protobuf wire-format byte stream, decodes each base-128 varint into an unsigned value, and pushes one entry per varint into the varint_out FIFO.
- The FIFO's read side is drained by the existing varint pop/valid/accepted FSM.
- Sits between the byte-stream splitter and the varint_out FIFO write port.

---
 rtl/varint_decode_push_if.sv | 38 +++
 rtl/varint_decode_push.sv | 123 ++++++++++++
 2 files changed

// File: rtl/varint_decode_push_if.sv
// Handshake bundle between the byte-stream splitter, varint_decode_push and the varint_out FIFO write port.
// With VARINT_ZIGZAG_EN defined the bundle also carries zigzag_mode.
interface varint_decode_push_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_accepted;
    logic                  varint_out_fifo_full;
    logic                  varint_out_push;
    logic [DATA_WIDTH-1:0] varint_out_data;
    logic [3:0]            varint_out_len;
    logic                  varint_error;

`ifdef VARINT_ZIGZAG_EN
    logic                  zigzag_mode;

    modport master (
        output byte_valid, byte_data, varint_out_fifo_full, zigzag_mode,
        input  byte_accepted, varint_out_push, varint_out_data, varint_out_len, varint_error
    );

    modport slave (
        input  byte_valid, byte_data, varint_out_fifo_full, zigzag_mode,
        output byte_accepted, varint_out_push, varint_out_data, varint_out_len, varint_error
    );
`else
    modport master (
        output byte_valid, byte_data, varint_out_fifo_full,
        input  byte_accepted, varint_out_push, varint_out_data, varint_out_len, varint_error
    );

    modport slave (
        input  byte_valid, byte_data, varint_out_fifo_full,
        output byte_accepted, varint_out_push, varint_out_data, varint_out_len, varint_error
    );
`endif
endinterface

// File: rtl/varint_decode_push.sv
// Decodes a protobuf base-128 varint byte stream and pushes one varint_out FIFO entry per varint.
// Optional macro VARINT_ZIGZAG_EN adds zigzag_mode for sint32/sint64 decoding of the pushed value.
module varint_decode_push #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BYTES  = 10
) (
    input logic                 clk,
    input logic                 reset,
    varint_decode_push_if.slave bus
);
    // One spare group of headroom so the overflow slice is never empty.
    localparam int EXT_W = 7 * MAX_BYTES + 7;

    typedef enum logic [1:0] {INIT, V_ACCUM, V_PUSH, V_ERROR} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            len_q, len_d;
    logic                  err_q, err_d;
    logic                  ended_q, ended_d;

    logic [EXT_W-1:0]      ext;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic [DATA_WIDTH-1:0] zz_value;
    logic                  overflow;
    logic                  last_idx;
    logic                  zig_sel;

`ifdef VARINT_ZIGZAG_EN
    assign zig_sel = bus.zigzag_mode;
`else
    assign zig_sel = 1'b0;
`endif

    assign ext      = EXT_W'(bus.byte_data[6:0]) << (7 * cnt_q);
    assign overflow = |ext[EXT_W-1:DATA_WIDTH];
    assign acc_sum  = acc_q | ext[DATA_WIDTH-1:0];
    assign last_idx = (cnt_q == 4'(MAX_BYTES - 1));
    assign zz_value = (acc_sum >> 1) ^ {DATA_WIDTH{acc_sum[0]}};

    // An overflow on a terminating byte has nothing left to drain, so the error
    // cycle must not swallow the first byte of the next varint.
    assign bus.byte_accepted   = (state_q == V_ACCUM) || ((state_q == V_ERROR) && !ended_q);
    assign bus.varint_out_push = (state_q == V_PUSH) && !bus.varint_out_fifo_full;
    assign bus.varint_out_data = data_q;
    assign bus.varint_out_len  = len_q;
    assign bus.varint_error    = err_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        len_d   = len_q;
        err_d   = 1'b0;
        ended_d = ended_q;
        unique case (state_q)
            INIT: begin
                state_d = V_ACCUM;
            end
            V_ACCUM: begin
                if (bus.byte_valid) begin
                    if (overflow) begin
                        state_d = V_ERROR;
                        err_d   = 1'b1;
                        ended_d = !bus.byte_data[7];
                    end else if (!bus.byte_data[7]) begin
                        data_d  = zig_sel ? zz_value : acc_sum;
                        len_d   = cnt_q + 4'd1;
                        state_d = V_PUSH;
                    end else if (last_idx) begin
                        state_d = V_ERROR;
                        err_d   = 1'b1;
                        ended_d = 1'b0;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            V_PUSH: begin
                if (!bus.varint_out_fifo_full) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = V_ACCUM;
                end
            end
            V_ERROR: begin
                if (ended_q || (bus.byte_valid && !bus.byte_data[7])) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ended_d = 1'b0;
                    state_d = V_ACCUM;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            acc_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            ended_q <= ended_d;
        end
    end
endmodule
